// File: rtl/eth_10g_mac_pause_pkg.sv
// eth_10g_mac_pause_pkg: constants and state type shared by the 10G MAC PAUSE frame generator.
package eth_10g_mac_pause_pkg;
    localparam logic [47:0] PAUSE_DA         = 48'h0180C2000001;
    localparam logic [15:0] MAC_CTRL_ETYPE   = 16'h8808;
    localparam logic [15:0] PAUSE_OPCODE     = 16'h0001;
    localparam int          PAUSE_BEATS      = 8;
    localparam logic [2:0]  PAUSE_LAST_EMPTY = 3'd4;
    typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/eth_10g_mac_tx_pause_frame_ctrl_if.sv
// eth_10g_mac_tx_pause_frame_ctrl_if: 64-bit Avalon-ST link from the PAUSE generator to the TX mux.
interface eth_10g_mac_tx_pause_frame_ctrl_if;
    logic        valid;
    logic        ready;
    logic [63:0] data;
    logic        startofpacket;
    logic        endofpacket;
    logic [2:0]  empty;
    logic [1:0]  error;
    modport master (output valid, data, startofpacket, endofpacket, empty, error, input ready);
    modport slave  (input valid, data, startofpacket, endofpacket, empty, error, output ready);
endinterface

// File: rtl/eth_10g_mac_pause_refresh_timer.sv
// eth_10g_mac_pause_refresh_timer: loadable down-counter; expire pulses on the 1->0 step.
module eth_10g_mac_pause_refresh_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         cnt <= '0;
        else if (load)        cnt <= load_val;
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end

    // a reload in the same cycle pre-empts the 1->0 step
    assign expire = (cnt == W'(1)) & ~load;
endmodule

// File: rtl/eth_10g_mac_tx_pause_frame_ctrl.sv
// eth_10g_mac_tx_pause_frame_ctrl: sequences 60-byte 802.3x XOFF/XON frames onto the TX flow-control port.
module eth_10g_mac_tx_pause_frame_ctrl
    import eth_10g_mac_pause_pkg::*;
#(
    parameter int HOLDOFF_W = 16,
    parameter bit XON_EN    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ctrl_enable,
    input  logic                 pause_req,
    input  logic [47:0]          cfg_src_mac,
    input  logic [15:0]          cfg_quanta,
    input  logic [HOLDOFF_W-1:0] cfg_holdoff,
    eth_10g_mac_tx_pause_frame_ctrl_if.master out,
    output logic                 busy,
    output logic                 frame_sent,
    output logic                 sent_xoff
);
    state_t      state, state_nx;
    logic [2:0]  beat;
    logic        req_q, xoff_pend, xon_pend, refr_pend;
    logic        xoff_nx, xon_nx, refr_nx;
    logic        start, last, expire, is_xoff;
    logic [47:0] sa;
    logic [15:0] quanta;
    logic        rise, fall;

    assign rise = pause_req & ~req_q;
    assign fall = ~pause_req & req_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        last     = 1'b0;
        if (state == IDLE) begin
            start    = ctrl_enable & (xon_pend | xoff_pend | refr_pend);
            state_nx = start ? SEND : IDLE;
        end else begin
            last     = out.ready & (beat == 3'(PAUSE_BEATS - 1));
            state_nx = last ? IDLE : SEND;
        end
    end

    // a start consumes every pending request; level at start picks the frame type
    always_comb begin
        xoff_nx = xoff_pend;
        xon_nx  = xon_pend;
        refr_nx = refr_pend;
        if (rise) begin
            xoff_nx = 1'b1;
            xon_nx  = 1'b0;
        end
        if (fall) begin
            xon_nx  = XON_EN;
            xoff_nx = 1'b0;
            refr_nx = 1'b0;
        end
        if (expire & pause_req) refr_nx = 1'b1;
        if (start) begin
            xoff_nx = 1'b0;
            xon_nx  = 1'b0;
            refr_nx = 1'b0;
        end
        if (last & xon_nx & ~xoff_nx & ~refr_nx & pause_req) xon_nx = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q      <= 1'b0;
            xoff_pend  <= 1'b0;
            xon_pend   <= 1'b0;
            refr_pend  <= 1'b0;
            beat       <= '0;
            is_xoff    <= 1'b0;
            sa         <= '0;
            quanta     <= '0;
            frame_sent <= 1'b0;
            sent_xoff  <= 1'b0;
        end else begin
            req_q      <= pause_req;
            xoff_pend  <= xoff_nx;
            xon_pend   <= xon_nx;
            refr_pend  <= refr_nx;
            frame_sent <= last;
            if (start) begin
                is_xoff <= pause_req;
                sa      <= cfg_src_mac;
                quanta  <= pause_req ? cfg_quanta : 16'h0;
                beat    <= '0;
            end else if (state == SEND && out.ready) begin
                beat <= beat + 3'd1;
            end
            if (last) sent_xoff <= is_xoff;
        end
    end

    eth_10g_mac_pause_refresh_timer #(.W(HOLDOFF_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (last & is_xoff & (cfg_holdoff != '0)),
        .load_val (cfg_holdoff),
        .expire   (expire)
    );

    assign out.valid         = (state == SEND);
    assign out.data          = !out.valid ? 64'h0 :
                               beat == 3'd0 ? {PAUSE_DA, sa[47:32]} :
                               beat == 3'd1 ? {sa[31:0], MAC_CTRL_ETYPE, PAUSE_OPCODE} :
                               beat == 3'd2 ? {quanta, 48'h0} : 64'h0;
    assign out.startofpacket = out.valid & (beat == 3'd0);
    assign out.endofpacket   = out.valid & (beat == 3'(PAUSE_BEATS - 1));
    assign out.empty         = out.endofpacket ? PAUSE_LAST_EMPTY : 3'd0;
    assign out.error         = 2'b00;
    assign busy              = out.valid;
endmodule

// File: tb/tb_eth_10g_mac_tx_pause_frame_ctrl.sv
// tb_eth_10g_mac_tx_pause_frame_ctrl: directed bench for the PAUSE frame generator (XON_EN=1 and XON_EN=0 instances).
module tb_eth_10g_mac_tx_pause_frame_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_enable = 1'b1;
    logic        pause_req = 1'b0;
    logic [47:0] cfg_src_mac;
    logic [15:0] cfg_quanta;
    logic [15:0] cfg_holdoff;
    logic        busy, frame_sent, sent_xoff;
    logic        busy2, frame_sent2, sent_xoff2;

    eth_10g_mac_tx_pause_frame_ctrl_if o ();
    eth_10g_mac_tx_pause_frame_ctrl_if o2 ();
    assign o2.ready = o.ready;

    eth_10g_mac_tx_pause_frame_ctrl #(.HOLDOFF_W(16), .XON_EN(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .ctrl_enable(ctrl_enable), .pause_req(pause_req),
        .cfg_src_mac(cfg_src_mac), .cfg_quanta(cfg_quanta), .cfg_holdoff(cfg_holdoff),
        .out(o), .busy(busy), .frame_sent(frame_sent), .sent_xoff(sent_xoff)
    );

    eth_10g_mac_tx_pause_frame_ctrl #(.HOLDOFF_W(16), .XON_EN(1'b0)) u_dut_noxon (
        .clk(clk), .reset_n(reset_n), .ctrl_enable(ctrl_enable), .pause_req(pause_req),
        .cfg_src_mac(cfg_src_mac), .cfg_quanta(cfg_quanta), .cfg_holdoff(cfg_holdoff),
        .out(o2), .busy(busy2), .frame_sent(frame_sent2), .sent_xoff(sent_xoff2)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0, failures = 0;
    bit          exp_types[$];
    logic [63:0] cap[$];
    int          sop_q[$], eop_q[$];
    int          bidx = 0, frames_seen = 0, fs_cnt = 0, fs2_cnt = 0, valid_cycles = 0;
    bit          in_frame = 0, cur_t = 0, rnd = 0;
    logic [47:0] exp_sa;
    logic [15:0] exp_q;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_beat(input int i, input bit t);
        case (i)
            0:       return {48'h0180C2000001, exp_sa[47:32]};
            1:       return {exp_sa[31:0], 32'h88080001};
            2:       return {t ? exp_q : 16'h0, 48'h0};
            default: return 64'h0;
        endcase
    endfunction

    // reference monitor: every valid cycle must present the modelled beat
    always @(negedge clk) begin
        if (!reset_n) begin
            bidx = 0;
            in_frame = 0;
        end else if (o.valid) begin
            valid_cycles++;
            if (!in_frame) begin
                if (exp_types.size() == 0) begin
                    chk("unexpected_frame", 64'd1, 64'd0);
                    cur_t = 1;
                end else begin
                    cur_t = exp_types.pop_front();
                end
                in_frame = 1;
                sop_q.push_back(cyc);
            end
            chk("data", o.data, exp_beat(bidx, cur_t));
            chk("sop", 64'(o.startofpacket), 64'(bidx == 0));
            chk("eop", 64'(o.endofpacket), 64'(bidx == 7));
            chk("empty", 64'(o.empty), (bidx == 7) ? 64'd4 : 64'd0);
            chk("error", 64'(o.error), 64'd0);
            if (o.ready) begin
                cap.push_back(o.data);
                if (bidx == 7) begin
                    eop_q.push_back(cyc);
                    frames_seen++;
                    in_frame = 0;
                    bidx = 0;
                end else begin
                    bidx++;
                end
            end
        end
        if (frame_sent) fs_cnt++;
        if (frame_sent2) fs2_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd) o.ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frames_seen < n && t < 3000) begin
            tick(1);
            t++;
        end
        chk("frame_wait", 64'(frames_seen >= n), 64'd1);
    endtask

    initial begin
        int base, f2, vc, t;
        cfg_src_mac = 48'h001122334455;
        cfg_quanta  = 16'hFFFF;
        cfg_holdoff = 16'd0;
        exp_sa = cfg_src_mac;
        exp_q  = cfg_quanta;
        o.ready = 1'b1;
        tick(3);
        chk("rst_valid", 64'(o.valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_sent", 64'(frame_sent), 64'd0);
        chk("rst_sent_xoff", 64'(sent_xoff), 64'd0);
        chk("rst_data", o.data, 64'd0);
        reset_n = 1'b1;
        tick(3);

        // basic XOFF then XON
        exp_types.push_back(1);
        pause_req = 1'b1;
        wait_frames(1);
        tick(2);
        chk("xoff_fs_cnt", 64'(fs_cnt), 64'd1);
        chk("xoff_sent_xoff", 64'(sent_xoff), 64'd1);
        chk("xoff_b0", cap[0], 64'h0180C20000010011);
        chk("xoff_b1", cap[1], 64'h2233445588080001);
        chk("xoff_b2", cap[2], 64'hFFFF000000000000);
        chk("xoff_b7", cap[7], 64'h0);
        exp_types.push_back(0);
        pause_req = 1'b0;
        wait_frames(2);
        tick(2);
        chk("xon_sent_xoff", 64'(sent_xoff), 64'd0);
        chk("xon_fs_cnt", 64'(fs_cnt), 64'd2);
        chk("xon_b0", cap[8], 64'h0180C20000010011);
        chk("xon_b2", cap[10], 64'h0);

        // periodic refresh with holdoff 100
        cfg_holdoff = 16'd100;
        base = sop_q.size();
        repeat (3) exp_types.push_back(1);
        pause_req = 1'b1;
        wait_frames(5);
        exp_types.push_back(0);
        pause_req = 1'b0;
        wait_frames(6);
        tick(2);
        chk("refresh_gap1", 64'(sop_q[base+1] - eop_q[base]), 64'd102);
        chk("refresh_gap2", 64'(sop_q[base+2] - eop_q[base+1]), 64'd102);
        chk("refresh_xon_type", 64'(sent_xoff), 64'd0);
        cfg_holdoff = 16'd0;
        tick(150);
        chk("refresh_quiet", 64'(frames_seen), 64'd6);

        // random backpressure, new SA/quanta
        cfg_src_mac = 48'hA1B2C3D4E5F6;
        cfg_quanta  = 16'h1234;
        exp_sa = cfg_src_mac;
        exp_q  = cfg_quanta;
        rnd = 1;
        exp_types.push_back(1);
        pause_req = 1'b1;
        wait_frames(7);
        exp_types.push_back(0);
        pause_req = 1'b0;
        wait_frames(8);
        rnd = 0;
        o.ready = 1'b1;
        tick(3);
        chk("bp_b1", cap[57], 64'hC3D4E5F688080001);
        chk("bp_xoff_b2", cap[50], 64'h1234000000000000);

        // 3-cycle pulse: XOFF then XON; XON_EN=0 instance sends XOFF only
        f2 = fs2_cnt;
        exp_types.push_back(1);
        exp_types.push_back(0);
        pause_req = 1'b1;
        tick(3);
        pause_req = 1'b0;
        wait_frames(10);
        tick(20);
        chk("pulse_noxon_frames", 64'(fs2_cnt - f2), 64'd1);
        chk("pulse_noxon_type", 64'(sent_xoff2), 64'd1);
        chk("pulse_xon_type", 64'(sent_xoff), 64'd0);
        chk("pulse_frames", 64'(frames_seen), 64'd10);

        // enable gating
        ctrl_enable = 1'b0;
        exp_types.push_back(1);
        pause_req = 1'b1;
        repeat (10) begin
            tick(1);
            chk("en_low_valid", 64'(o.valid), 64'd0);
        end
        ctrl_enable = 1'b1;
        chk("en_same_cycle", 64'(o.valid), 64'd0);
        tick(1);
        chk("en_next_valid", 64'(o.valid), 64'd1);
        chk("en_next_sop", 64'(o.startofpacket), 64'd1);
        wait_frames(11);
        tick(2);
        chk("en_sent_xoff", 64'(sent_xoff), 64'd1);

        // async reset at beat 4 of an XON frame
        exp_types.push_back(0);
        pause_req = 1'b0;
        t = 0;
        while (bidx != 4 && t < 100) begin
            tick(1);
            t++;
        end
        chk("reach_beat4", 64'(bidx), 64'd4);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(o.valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_data", o.data, 64'd0);
        vc = valid_cycles;
        tick(3);
        chk("arst_sent_xoff", 64'(sent_xoff), 64'd0);
        reset_n = 1'b1;
        tick(40);
        chk("post_rst_idle", 64'(valid_cycles), 64'(vc));
        chk("fs_vs_seen", 64'(fs_cnt), 64'(frames_seen));
        chk("exp_drained", 64'(exp_types.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
